// File: rtl/coreaxi4dmacontroller_dscrptr_sched.sv
// Descriptor scheduler: two-level arbitration (high group first, round-robin
// within each group). It offers one descriptor at a time to the transfer
// engine, waits for its chunk acknowledge, and pulses a clear back to the
// descriptor bank on a done ack.
// Optional feature macro: COREAXI4DMACONTROLLER_STARVE_PROMOTE_EN (starvation
// promotion of the low group after STARVE_LIMIT consecutive high grants).
module coreaxi4dmacontroller_dscrptr_sched #(
    parameter int NUM_DSCRPTRS      = 4,
    parameter int DSCRPTR_NUM_WIDTH = 2,
    parameter int STARVE_LIMIT      = 8,
    parameter int STARVE_CNT_WIDTH  = 4
) (
    input  logic                         CLOCK,
    input  logic                         RESET,
    input  logic                         enable,
    input  logic [NUM_DSCRPTRS-1:0]      dscrptrValid,
    input  logic [NUM_DSCRPTRS-1:0]      dscrptrPri,
    output logic                         issueValid,
    output logic [DSCRPTR_NUM_WIDTH-1:0] issueNum,
    input  logic                         issueReady,
    input  logic                         ackValid,
    input  logic [DSCRPTR_NUM_WIDTH-1:0] ackNum,
    input  logic                         ackDone,
    output logic                         clrValid,
    output logic [DSCRPTR_NUM_WIDTH-1:0] clrNum,
    output logic                         busy,
    output logic                         ackErr
);

    typedef enum logic [3:0] {
        IDLE     = 4'b0001,
        ARB      = 4'b0010,
        ISSUE    = 4'b0100,
        WAIT_ACK = 4'b1000
    } state_t;

    localparam logic [DSCRPTR_NUM_WIDTH-1:0] LAST_IDX = DSCRPTR_NUM_WIDTH'(NUM_DSCRPTRS - 1);

    // Parameter sanity checks at elaboration time.
    if ((1 << DSCRPTR_NUM_WIDTH) < NUM_DSCRPTRS) begin : g_bad_num_width
        $error("DSCRPTR_NUM_WIDTH too small for NUM_DSCRPTRS");
    end
    if (STARVE_LIMIT >= (1 << STARVE_CNT_WIDTH)) begin : g_bad_starve_width
        $error("STARVE_CNT_WIDTH cannot hold STARVE_LIMIT");
    end

    // Round-robin search: nearest set bit strictly after ptr, wrapping.
    // Scanning from farthest to nearest lets the nearest hit win.
    function automatic logic [DSCRPTR_NUM_WIDTH:0] rr_pick(
        input logic [NUM_DSCRPTRS-1:0]      req,
        input logic [DSCRPTR_NUM_WIDTH-1:0] ptr
    );
        logic [DSCRPTR_NUM_WIDTH:0] res;
        int idx;
        res = '0;
        for (int k = NUM_DSCRPTRS; k >= 1; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_DSCRPTRS) idx = idx - NUM_DSCRPTRS;
            if (req[DSCRPTR_NUM_WIDTH'(idx)]) res = {1'b1, DSCRPTR_NUM_WIDTH'(idx)};
        end
        return res;
    endfunction

    state_t                         state_reg, state_next;
    logic                           issue_valid_reg, issue_valid_next;
    logic [DSCRPTR_NUM_WIDTH-1:0]   issue_num_reg, issue_num_next;
    logic                           group_hi_reg, group_hi_next;
    logic [DSCRPTR_NUM_WIDTH-1:0]   ptr_hi_reg, ptr_hi_next;
    logic [DSCRPTR_NUM_WIDTH-1:0]   ptr_lo_reg, ptr_lo_next;
    logic                           clr_valid_reg, clr_valid_next;
    logic [DSCRPTR_NUM_WIDTH-1:0]   clr_num_reg, clr_num_next;
    logic                           busy_reg, busy_next;
    logic                           ack_err_reg, ack_err_next;

    logic [NUM_DSCRPTRS-1:0]        cand;
    logic [NUM_DSCRPTRS-1:0]        hi_req, lo_req;
    logic [DSCRPTR_NUM_WIDTH:0]     hi_pick, lo_pick;
    logic                           ack_match;
    logic                           force_lo;

    // A descriptor being cleared this cycle is still shown valid by the bank;
    // hide it so it cannot be re-issued.
    for (genvar gi = 0; gi < NUM_DSCRPTRS; gi++) begin : g_cand
        assign cand[gi] = dscrptrValid[gi] &
                          ~(clr_valid_reg & (clr_num_reg == DSCRPTR_NUM_WIDTH'(gi)));
    end

    assign hi_req    = cand & dscrptrPri;
    assign lo_req    = cand & ~dscrptrPri;
    assign hi_pick   = rr_pick(hi_req, ptr_hi_reg);
    assign lo_pick   = rr_pick(lo_req, ptr_lo_reg);
    assign ack_match = (state_reg == WAIT_ACK) && (ackNum == issue_num_reg);

`ifdef COREAXI4DMACONTROLLER_STARVE_PROMOTE_EN
    logic [STARVE_CNT_WIDTH-1:0] starve_cnt_reg, starve_cnt_next;
    assign force_lo = (starve_cnt_reg == STARVE_CNT_WIDTH'(STARVE_LIMIT)) && (lo_req != '0);
`else
    assign force_lo = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_next       = state_reg;
        issue_valid_next = issue_valid_reg;
        issue_num_next   = issue_num_reg;
        group_hi_next    = group_hi_reg;
        ptr_hi_next      = ptr_hi_reg;
        ptr_lo_next      = ptr_lo_reg;
        clr_valid_next   = 1'b0;
        clr_num_next     = clr_num_reg;
        ack_err_next     = ack_err_reg | (ackValid & ~ack_match);
`ifdef COREAXI4DMACONTROLLER_STARVE_PROMOTE_EN
        starve_cnt_next  = starve_cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (enable && (dscrptrValid != '0)) state_next = ARB;
            end
            ARB: begin
                if (!enable || (cand == '0)) begin
                    state_next = IDLE;
                end else begin
                    state_next       = ISSUE;
                    issue_valid_next = 1'b1;
                    if ((hi_req == '0) || force_lo) begin
                        issue_num_next = lo_pick[DSCRPTR_NUM_WIDTH-1:0];
                        group_hi_next  = 1'b0;
                    end else begin
                        issue_num_next = hi_pick[DSCRPTR_NUM_WIDTH-1:0];
                        group_hi_next  = 1'b1;
                    end
`ifdef COREAXI4DMACONTROLLER_STARVE_PROMOTE_EN
                    if ((hi_req == '0) || force_lo || (lo_req == '0))
                        starve_cnt_next = '0;
                    else if (starve_cnt_reg != STARVE_CNT_WIDTH'(STARVE_LIMIT))
                        starve_cnt_next = starve_cnt_reg + 1'b1;
`endif
                end
            end
            ISSUE: begin
                if (issueReady) begin
                    issue_valid_next = 1'b0;
                    state_next       = WAIT_ACK;
                    if (group_hi_reg) ptr_hi_next = issue_num_reg;
                    else              ptr_lo_next = issue_num_reg;
                end
            end
            WAIT_ACK: begin
                if (ackValid && ack_match) begin
                    if (ackDone) begin
                        clr_valid_next = 1'b1;
                        clr_num_next   = ackNum;
                    end
                    state_next = enable ? ARB : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_reg       <= IDLE;
            issue_valid_reg <= 1'b0;
            issue_num_reg   <= '0;
            group_hi_reg    <= 1'b0;
            ptr_hi_reg      <= LAST_IDX;
            ptr_lo_reg      <= LAST_IDX;
            clr_valid_reg   <= 1'b0;
            clr_num_reg     <= '0;
            busy_reg        <= 1'b0;
            ack_err_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            issue_valid_reg <= issue_valid_next;
            issue_num_reg   <= issue_num_next;
            group_hi_reg    <= group_hi_next;
            ptr_hi_reg      <= ptr_hi_next;
            ptr_lo_reg      <= ptr_lo_next;
            clr_valid_reg   <= clr_valid_next;
            clr_num_reg     <= clr_num_next;
            busy_reg        <= busy_next;
            ack_err_reg     <= ack_err_next;
        end
    end

`ifdef COREAXI4DMACONTROLLER_STARVE_PROMOTE_EN
    // Consecutive high-group grant counter while low-group work waits.
    always_ff @(posedge CLOCK) begin
        if (RESET) starve_cnt_reg <= '0;
        else       starve_cnt_reg <= starve_cnt_next;
    end
`endif

    assign issueValid = issue_valid_reg;
    assign issueNum   = issue_num_reg;
    assign clrValid   = clr_valid_reg;
    assign clrNum     = clr_num_reg;
    assign busy       = busy_reg;
    assign ackErr     = ack_err_reg;

endmodule
